mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width (even, >= 4).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, giving the iteration counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 SHALL have port op  input  5  operation code: MULT 5'b10010, MULTU 5'b10011, DIV 5'b10100, DIVU 5'b10101.
REQ-007 SHALL have port a  input  WIDTH  multiplicand or dividend (rs).
REQ-008 SHALL have port b  input  WIDTH  multiplier or divisor (rt).
REQ-009 SHALL have port cancel  input  1  pipeline flush; aborts the operation in flight.
REQ-010 SHALL have port hi_we  input  1  direct write of HI (MTHI).
REQ-011 SHALL have port lo_we  input  1  direct write of LO (MTLO).
REQ-012 SHALL have port wdata  input  WIDTH  data for hi_we/lo_we.
REQ-013 SHALL have port busy  output  1  an operation is in flight; the stage must stall.
REQ-014 SHALL have port done  output  1  one-cycle pulse; HI/LO hold a new result.
REQ-015 SHALL have port div_zero  output  1  sticky flag; last completed divide had b==0.
REQ-016 SHALL have port hi  output  WIDTH  HI register (high product / remainder).
REQ-017 SHALL have port lo  output  WIDTH  LO register (low product / quotient).

Function
REQ-018 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; start with a legal op in IDLE goes to CALC; start with any other op is ignored.
REQ-019 SHALL on acceptance latch the magnitudes of a and b (absolute values for MULT/DIV, raw for MULTU/DIVU), the two operand signs and the op, and load the counter with WIDTH.
REQ-020 SHALL in CALC perform one radix-2 step per cycle (shift-add multiply, restoring divide) on WIDTH+1-bit partials, decrementing the counter; go to FIX when the counter reaches 1.
REQ-021 SHALL in FIX apply the sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes the sign of the dividend), write {hi,lo} at the end of FIX, and return to IDLE.
REQ-022 SHALL assert done for exactly the first cycle after the FIX edge, and assert busy for every cycle that state is CALC or FIX, i.e. cycles 1..WIDTH+1 after the accepting edge; the total latency is WIDTH+1 cycles.
REQ-023 SHALL, when divisor == 0, set lo = all ones and hi = a, and set div_zero; any completed non-zero divide clears div_zero, and a multiply leaves div_zero unchanged.
REQ-024 SHALL, for signed DIV of the minimum value by -1, produce lo = minimum value and hi = 0, with no exception.
REQ-025 SHALL, when cancel is asserted in CALC or FIX, return to IDLE at the next edge, leave hi, lo and div_zero unchanged, and generate no done pulse.
REQ-026 SHALL treat cancel together with start in IDLE as no acceptance.
REQ-027 SHALL apply hi_we/lo_we writes at the next edge in any state; a FIX-edge result write takes priority over a simultaneous direct write.
REQ-028 SHALL not accept a new start in the same cycle that done is high unless state is IDLE; back-to-back issue is therefore possible with done and start in the same cycle.
REQ-029 SHALL ignore changes on a and b after acceptance.

Reset
REQ-030 SHALL on rst force, asynchronously and mid-operation included, state = IDLE, counter = 0, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0.
REQ-031 SHALL accept start in the first cycle after rst deasserts.

Structure
REQ-032 SHALL take the opcode constants (MULT, MULTU, DIV, DIVU) and the FSM state encoding from a shared package, alu_pkg, also used by alu.
REQ-033 SHALL contain one sub-module, mdu_iter, holding the single-step datapath (add/subtract-shift on the partial remainder or product); the FSM, sign fix-up and HI/LO registers stay in the top.

Verification
REQ-034 SHALL cover MULT with WIDTH=32, a=-3 (0xFFFFFFFD), b=7 -> done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 SHALL cover MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 SHALL cover DIV with a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
REQ-037 SHALL cover DIVU with a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1.
REQ-038 SHALL cover DIV with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 SHALL cover cancel in CALC cycle 10 of a MULT with hi/lo preloaded via hi_we/lo_we to 0xA5A5A5A5 -> no done pulse, busy low next cycle, hi/lo still 0xA5A5A5A5; then rst mid-DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/MDU definitions: HI/LO opcode constants and the multiply/divide FSM encoding.
package alu_pkg;

  localparam int unsigned OP_W = 5;
  localparam int unsigned ST_W = 2;

  localparam logic [OP_W-1:0] OP_MULT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_MULTU = 5'b10011;
  localparam logic [OP_W-1:0] OP_DIV   = 5'b10100;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'b10101;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_CALC = 2'd1;
  localparam logic [ST_W-1:0] ST_FIX  = 2'd2;

  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// One radix-2 step: shift-add multiply or restoring divide on unsigned magnitudes.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,   // high product half / partial remainder
  input  logic [WIDTH-1:0] i_lo,    // multiplier bits / dividend-quotient bits
  input  logic [WIDTH-1:0] i_opnd,  // multiplicand / divisor
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Next partial: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
  always_comb begin
    w_sum   = {1'b0, i_acc} + {1'b0, i_opnd};
    w_add   = i_lo[0] ? w_sum : {1'b0, i_acc};
    w_shift = {i_acc, i_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_opnd};
    if (i_is_div) begin
      // Remainder is always below the divisor, so a borrow shows up in the top bit.
      if (w_diff[WIDTH]) begin
        o_acc = w_shift[WIDTH-1:0];
        o_lo  = {i_lo[WIDTH-2:0], 1'b0};
      end else begin
        o_acc = w_diff[WIDTH-1:0];
        o_lo  = {i_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      o_acc = w_add[WIDTH:1];
      o_lo  = {w_add[0], i_lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; WIDTH+1 cycle latency.
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst,
  mul_div_unit_if.slave bus
);
  logic [ST_W-1:0]  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_wlo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic               w_accept;
  logic               w_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_wlo_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic               w_res_dz;
  logic               w_write_res;

  // Acceptance decode and operand magnitudes (signed ops iterate on absolute values)
  always_comb begin
    w_accept = (r_state == ST_IDLE) && bus.start && !bus.cancel && is_md_op(bus.op);
    w_signed = op_is_signed(bus.op);
    w_sign_a = w_signed && bus.a[WIDTH-1];
    w_sign_b = w_signed && bus.b[WIDTH-1];
    w_mag_a  = w_sign_a ? -bus.a : bus.a;
    w_mag_b  = w_sign_b ? -bus.b : bus.b;
  end

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .i_is_div(r_is_div),
    .i_acc   (r_acc),
    .i_lo    (r_wlo),
    .i_opnd  (r_opnd),
    .o_acc   (w_acc_nxt),
    .o_lo    (w_wlo_nxt)
  );

  // Sign fix-up of the raw magnitude result, evaluated while in FIX
  always_comb begin
    w_prod     = {r_acc, r_wlo};
    w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    w_res_dz   = (r_opnd == '0);
    if (r_is_div) begin
      w_res_lo = (r_sign_a ^ r_sign_b) ? -r_wlo : r_wlo;
      // With a zero divisor the remainder ends up as |a|, so this also yields hi = a.
      w_res_hi = r_sign_a ? -r_acc : r_acc;
      if (w_res_dz) begin
        w_res_lo = '1;
      end
    end else begin
      w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
    end
    w_write_res = (r_state == ST_FIX) && !bus.cancel;
  end

  // FSM, iteration counter and working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_wlo    <= '0;
      r_opnd   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_CALC;
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= op_is_div(bus.op);
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_acc    <= '0;
            // Divide shifts the dividend out of the low word; multiply shifts the multiplier.
            r_wlo    <= op_is_div(bus.op) ? w_mag_a : w_mag_b;
            r_opnd   <= op_is_div(bus.op) ? w_mag_b : w_mag_a;
          end
        end
        ST_CALC: begin
          if (bus.cancel) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_wlo <= w_wlo_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // HI/LO, sticky divide-by-zero and done pulse; a result write beats MTHI/MTLO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= w_write_res;
      if (w_write_res) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
        if (r_is_div) begin
          r_div_zero <= w_res_dz;
        end
      end else begin
        if (bus.hi_we) begin
          r_hi <= bus.wdata;
        end
        if (bus.lo_we) begin
          r_lo <= bus.wdata;
        end
      end
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus cancel, priority and reset sequences.
module tb_mul_div_unit;

  localparam logic [4:0] T_MULT  = 5'b10010;
  localparam logic [4:0] T_MULTU = 5'b10011;
  localparam logic [4:0] T_DIV   = 5'b10100;
  localparam logic [4:0] T_DIVU  = 5'b10101;
  localparam int         LAT     = 33;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  vec_t vecs[12];

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Issue one op from a post-edge sample point and check latency, busy window and results.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input string name);
    int lat;
    int busy_cnt;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 5'($urandom());
    bus.a     = $urandom();
    bus.b     = $urandom();
    check({name, " done low after accept"}, 64'(bus.done), 64'd0);
    busy_cnt = int'(bus.busy);
    lat      = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      busy_cnt += int'(bus.busy);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " busy cycles"}, 64'(busy_cnt), 64'(LAT));
    check({name, " hi"}, 64'(bus.hi), 64'(ehi));
    check({name, " lo"}, 64'(bus.lo), 64'(elo));
    check({name, " div_zero"}, 64'(bus.div_zero), 64'(edz));
  endtask

  initial begin
    logic seen_done;
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{T_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_m3x7"};
    vecs[1]  = '{T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
    vecs[2]  = '{T_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7d2"};
    vecs[3]  = '{T_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, "divu_zero"};
    vecs[4]  = '{T_MULT,  32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E, 1'b1, "mult_keep_dz"};
    vecs[5]  = '{T_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_min_m1"};
    vecs[6]  = '{T_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, "divu_100d7"};
    vecs[7]  = '{T_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, "multu_2p32"};
    vecs[8]  = '{T_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7dm2"};
    vecs[9]  = '{T_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, "div_m8_zero"};
    vecs[10] = '{T_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1, "mult_min_sq"};
    vecs[11] = '{T_MULT,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "mult_m1x1"};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cancel = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    rst = 1'b0;

    // Back-to-back table: each op starts in the cycle where the previous done is high.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].name);
    end

    // Illegal opcode is ignored.
    bus.start = 1'b1;
    bus.op    = 5'b00000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("illegal op busy", 64'(bus.busy), 64'd0);

    // Cancel together with start in IDLE is not an acceptance.
    bus.start  = 1'b1;
    bus.op     = T_MULT;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("cancel+start busy", 64'(bus.busy), 64'd0);

    // Preload HI/LO, then cancel a MULT in CALC cycle 10.
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("preload hi", 64'(bus.hi), 64'hA5A5A5A5);
    check("preload lo", 64'(bus.lo), 64'hA5A5A5A5);
    bus.start = 1'b1;
    bus.op    = T_MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("cancel pre busy", 64'(bus.busy), 64'd1);
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel busy next", 64'(bus.busy), 64'd0);
    seen_done = bus.done;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("cancel no done", 64'(seen_done), 64'd0);
    check("cancel hi kept", 64'(bus.hi), 64'hA5A5A5A5);
    check("cancel lo kept", 64'(bus.lo), 64'hA5A5A5A5);
    check("cancel dz kept", 64'(bus.div_zero), 64'd1);

    // Result write in FIX wins over simultaneous MTHI/MTLO.
    bus.start = 1'b1;
    bus.op    = T_MULTU;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("fix busy", 64'(bus.busy), 64'd1);
    check("fix done low", 64'(bus.done), 64'd0);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("prio done", 64'(bus.done), 64'd1);
    check("prio hi", 64'(bus.hi), 64'd0);
    check("prio lo", 64'(bus.lo), 64'd6);
    @(posedge clk); #1;
    check("done one cycle", 64'(bus.done), 64'd0);

    // MTHI during a DIV, then asynchronous reset mid-operation.
    bus.start = 1'b1;
    bus.op    = T_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h00001111;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi in calc hi", 64'(bus.hi), 64'h1111);
    check("mthi in calc busy", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", 64'(bus.busy), 64'd0);
    check("async rst done", 64'(bus.done), 64'd0);
    check("async rst div_zero", 64'(bus.div_zero), 64'd0);
    check("async rst hi", 64'(bus.hi), 64'd0);
    check("async rst lo", 64'(bus.lo), 64'd0);
    #1 rst = 1'b0;

    // Start is accepted in the first cycle after reset release.
    run_op(T_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "post_rst_divu");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
